systolic_sequencer: RTL and testbench
=====================================

Name: systolic_sequencer

Overview:
Command-driven controller that sequences one systolic array cluster. It accepts one tile command at a time, then drives the cluster's control and operand inputs through these phases in order: accumulator clear, weight load, activation streaming, pipeline drain, and a ready wait. Operands arrive on a valid/ready stream. The block sits in the core between the scheduler/decoder and the cluster, and replaces the cluster control signals that are currently tied off.

Parameters:
DATA_BITS, 16, Q1.15 operand width
ARRAY_SIZE, 8, PE rows/cols per array
NUM_ARRAYS, 8, arrays in cluster
K_BITS, 8, width of stream-length field

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE
cmd_array  in  $clog2(NUM_ARRAYS)  target array
cmd_k_len  in  K_BITS  activation rows to stream (0 allowed)
cmd_clear  in  1  clear accumulators first
cmd_load  in  1  load weights first
cmd_broadcast  in  1  drive all arrays
abort  in  1  synchronous abort
op_valid  in  1  operand beat offered
op_ready  out  1  high in LOAD/COMPUTE
op_a  in  ARRAY_SIZE*DATA_BITS  activation row, packed, lane 0 = LSBs
op_b  in  ARRAY_SIZE*DATA_BITS  weight row, packed
array_select  out  $clog2(NUM_ARRAYS)  to cluster
clear_acc  out  1  to cluster
load_weights  out  1  to cluster
compute_enable  out  1  to cluster
broadcast_mode  out  1  to cluster
a_inputs  out  ARRAY_SIZE*DATA_BITS  to cluster
b_inputs  out  ARRAY_SIZE*DATA_BITS  to cluster
all_ready  in  NUM_ARRAYS  per-array ready from cluster
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (reset=0, asynchronous): enter IDLE; clear all counters and latched command fields. While in reset, every output is 0 except cmd_ready, which is 1.
- Command handshake: a command is accepted on a cycle with cmd_valid && cmd_ready. On acceptance, latch array, k_len, clear, load and broadcast. cmd_ready is 0 in every state other than IDLE.
- States: IDLE, CLEAR, LOAD, COMPUTE, DRAIN, WAIT_RDY, DONE.
- Next state after acceptance, in priority order: CLEAR if clear=1; else LOAD if load=1; else COMPUTE if k_len!=0; else WAIT_RDY.
- CLEAR: lasts exactly 1 cycle with clear_acc=1. Then go to LOAD / COMPUTE / WAIT_RDY by the same priority.
- LOAD: op_ready=1. load_weights = op_valid, and b_inputs = op_b on that beat. The beat counter increments on each handshake. After ARRAY_SIZE beats, go to COMPUTE if k_len!=0, else WAIT_RDY.
- COMPUTE: op_ready=1. compute_enable = op_valid; a_inputs = op_a and b_inputs = op_b on that beat. After k_len beats, go to DRAIN.
- DRAIN: compute_enable=1 with a_inputs = b_inputs = 0 for exactly 2*ARRAY_SIZE-1 cycles, then go to WAIT_RDY.
- WAIT_RDY: stay until the ready condition is high, then go to DONE. Ready condition: all_ready[array] when broadcast=0; &all_ready when broadcast=1. The minimum residence is 1 cycle.
- DONE: done=1 for 1 cycle, then go to IDLE.
- Operand buses: a_inputs and b_inputs are 0 whenever no handshake occurs (operand stalls insert bubbles). load_weights and compute_enable are never high without a handshake, except in DRAIN.
- Output timing: cluster controls are combinational from the registered state plus the current-cycle op handshake, adding zero latency. array_select and broadcast_mode hold the latched values from acceptance until IDLE, and are 0 in IDLE.
- Abort: if abort=1 in any state other than IDLE, go to IDLE next cycle with no done pulse. The current-cycle outputs still follow the present state. abort in IDLE is ignored, and abort has priority over every other transition.
- Counters: the beat counter is K_BITS wide and is cleared on each state entry. k_len=255 must complete without wrap. A command with load=0, clear=0 and k_len=0 is legal: IDLE→WAIT_RDY→DONE.
- Back-to-back commands: a new command is accepted at the earliest in the IDLE cycle after DONE.

Test Plan:
- Full op, no stalls. Accept at cycle T with clear=1, load=1, k_len=4, array=3; all_ready=8'hFF; op_valid held 1. Required: clear_acc at T+1; load_weights T+2..T+9; compute_enable with data T+10..T+13; drain T+14..T+28 with zero inputs; WAIT_RDY T+29; done at T+30; array_select=3 throughout; cmd_ready=1 at T+31.
- Operand stalls. Same command, with op_valid deasserted every other cycle in LOAD/COMPUTE. Required: exactly 8 load_weights pulses and 4 compute_enable pulses; inputs 0 on bubble cycles; done 4+8 cycles later than the no-stall case.
- Ready wait and broadcast. broadcast=1, k_len=1, with all_ready=8'hFE for 5 cycles after DRAIN and then 8'hFF. Required: done exactly 1 cycle after all_ready reaches 8'hFF; broadcast_mode=1 until IDLE.
- Degenerate commands. clear=0, load=0, k_len=0 → done 2 cycles after acceptance. clear=0, load=1, k_len=0 → 8 load beats, no DRAIN, then WAIT_RDY.
- Abort and reset mid-op. Assert abort during the 3rd COMPUTE beat → IDLE next cycle, no done, cmd_ready=1. Drop reset asynchronously during DRAIN → all outputs 0 immediately, except cmd_ready=1.
- Busy rejection and k_len=255. Hold cmd_valid with new fields while busy → not accepted, and latched fields are unchanged. A k_len=255 command → exactly 255 compute beats, then drain.

Source files
------------

// File: rtl/systolic_sequencer.sv
// systolic_sequencer: command-driven control sequencer for one systolic array
// cluster. It walks each accepted tile command through accumulator clear,
// weight load, activation streaming, pipeline drain and a cluster-ready wait.
// The operand stream is passed straight through to the cluster on handshake
// cycles.
module systolic_sequencer #(
   parameter int DATA_BITS  = 16,
   parameter int ARRAY_SIZE = 8,
   parameter int NUM_ARRAYS = 8,
   parameter int K_BITS     = 8
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               cmd_valid,
   output logic                               cmd_ready,
   input  logic [$clog2(NUM_ARRAYS)-1:0]      cmd_array,
   input  logic [K_BITS-1:0]                  cmd_k_len,
   input  logic                               cmd_clear,
   input  logic                               cmd_load,
   input  logic                               cmd_broadcast,
   input  logic                               abort,
   input  logic                               op_valid,
   output logic                               op_ready,
   input  logic [ARRAY_SIZE*DATA_BITS-1:0]    op_a,
   input  logic [ARRAY_SIZE*DATA_BITS-1:0]    op_b,
   output logic [$clog2(NUM_ARRAYS)-1:0]      array_select,
   output logic                               clear_acc,
   output logic                               load_weights,
   output logic                               compute_enable,
   output logic                               broadcast_mode,
   output logic [ARRAY_SIZE*DATA_BITS-1:0]    a_inputs,
   output logic [ARRAY_SIZE*DATA_BITS-1:0]    b_inputs,
   input  logic [NUM_ARRAYS-1:0]              all_ready,
   output logic                               busy,
   output logic                               done
);

   localparam int SEL_BITS   = $clog2(NUM_ARRAYS);
   localparam int BUS_BITS   = ARRAY_SIZE * DATA_BITS;
   localparam int DRAIN_BITS = $clog2(2 * ARRAY_SIZE);
   // The beat counter must hold both the longest stream and the drain length.
   localparam int CNT_BITS   = (K_BITS > DRAIN_BITS) ? K_BITS : DRAIN_BITS;
   localparam logic [CNT_BITS-1:0] LOAD_LAST  = CNT_BITS'(ARRAY_SIZE - 1);
   localparam logic [CNT_BITS-1:0] DRAIN_LAST = CNT_BITS'(2 * ARRAY_SIZE - 2);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      LOAD,
      COMPUTE,
      DRAIN,
      WAIT_RDY,
      DONE
   } state_t;

   state_t                state;
   state_t                state_next;
   logic [CNT_BITS-1:0]   beat_cnt;
   logic                  cnt_step;
   logic [SEL_BITS-1:0]   lat_array;
   logic [K_BITS-1:0]     lat_k_len;
   logic                  lat_clear;
   logic                  lat_load;
   logic                  lat_broadcast;
   logic                  ready_ok;
   logic                  k_last;

   // Shared routing after acceptance or CLEAR: the first enabled phase wins.
   function automatic state_t route(input logic do_clear, input logic do_load,
                                    input logic k_nonzero);
      if (do_clear)
         return CLEAR;
      else if (do_load)
         return LOAD;
      else if (k_nonzero)
         return COMPUTE;
      else
         return WAIT_RDY;
   endfunction

   assign ready_ok = lat_broadcast ? (&all_ready) : all_ready[lat_array];
   assign k_last   = (beat_cnt + CNT_BITS'(1)) == CNT_BITS'(lat_k_len);

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state selection and all cluster-facing outputs for the present state.
   always_comb begin
      state_next     = state;
      cmd_ready      = 1'b0;
      op_ready       = 1'b0;
      clear_acc      = 1'b0;
      load_weights   = 1'b0;
      compute_enable = 1'b0;
      a_inputs       = '0;
      b_inputs       = '0;
      busy           = 1'b1;
      done           = 1'b0;
      cnt_step       = 1'b0;
      array_select   = lat_array;
      broadcast_mode = lat_broadcast;
      case (state)
         IDLE: begin
            cmd_ready      = 1'b1;
            busy           = 1'b0;
            array_select   = '0;
            broadcast_mode = 1'b0;
            if (cmd_valid)
               state_next = route(cmd_clear, cmd_load, cmd_k_len != '0);
         end
         CLEAR: begin
            clear_acc  = lat_clear;
            state_next = route(1'b0, lat_load, lat_k_len != '0);
         end
         LOAD: begin
            op_ready     = 1'b1;
            load_weights = op_valid;
            cnt_step     = op_valid;
            if (op_valid)
               b_inputs = op_b;
            if (op_valid && beat_cnt == LOAD_LAST)
               state_next = (lat_k_len != '0) ? COMPUTE : WAIT_RDY;
         end
         COMPUTE: begin
            op_ready       = 1'b1;
            compute_enable = op_valid;
            cnt_step       = op_valid;
            if (op_valid) begin
               a_inputs = op_a;
               b_inputs = op_b;
            end
            if (op_valid && k_last)
               state_next = DRAIN;
         end
         DRAIN: begin
            compute_enable = 1'b1;
            cnt_step       = 1'b1;
            if (beat_cnt == DRAIN_LAST)
               state_next = WAIT_RDY;
         end
         WAIT_RDY: begin
            if (ready_ok)
               state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      // Abort overrides every transition but not the present-cycle outputs.
      if (abort && state != IDLE)
         state_next = IDLE;
   end

   // Beat counter: restarts on every state entry, advances on counted cycles.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         beat_cnt <= '0;
      else if (state_next != state)
         beat_cnt <= '0;
      else if (cnt_step)
         beat_cnt <= beat_cnt + CNT_BITS'(1);
   end

   // Command fields are captured only on the accepting IDLE cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lat_array     <= '0;
         lat_k_len     <= '0;
         lat_clear     <= 1'b0;
         lat_load      <= 1'b0;
         lat_broadcast <= 1'b0;
      end else if (state == IDLE && cmd_valid) begin
         lat_array     <= cmd_array;
         lat_k_len     <= cmd_k_len;
         lat_clear     <= cmd_clear;
         lat_load      <= cmd_load;
         lat_broadcast <= cmd_broadcast;
      end
   end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Testbench for systolic_sequencer: a table of tile commands with expected
// phase timing and beat counts, an operand scoreboard checking pass-through
// order and data, plus hand-written abort and mid-operation reset sequences.
module tb_systolic_sequencer;

   localparam int DATA_BITS  = 16;
   localparam int ARRAY_SIZE = 8;
   localparam int NUM_ARRAYS = 8;
   localparam int K_BITS     = 8;
   localparam int W          = ARRAY_SIZE * DATA_BITS;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [2:0]           cmd_array;
   logic [K_BITS-1:0]    cmd_k_len;
   logic                 cmd_clear;
   logic                 cmd_load;
   logic                 cmd_broadcast;
   logic                 abort;
   logic                 op_valid;
   logic                 op_ready;
   logic [W-1:0]         op_a;
   logic [W-1:0]         op_b;
   logic [2:0]           array_select;
   logic                 clear_acc;
   logic                 load_weights;
   logic                 compute_enable;
   logic                 broadcast_mode;
   logic [W-1:0]         a_inputs;
   logic [W-1:0]         b_inputs;
   logic [NUM_ARRAYS-1:0] all_ready;
   logic                 busy;
   logic                 done;
   logic [10:0]          ctl;

   systolic_sequencer #(
      .DATA_BITS (DATA_BITS),
      .ARRAY_SIZE(ARRAY_SIZE),
      .NUM_ARRAYS(NUM_ARRAYS),
      .K_BITS    (K_BITS)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_array     (cmd_array),
      .cmd_k_len     (cmd_k_len),
      .cmd_clear     (cmd_clear),
      .cmd_load      (cmd_load),
      .cmd_broadcast (cmd_broadcast),
      .abort         (abort),
      .op_valid      (op_valid),
      .op_ready      (op_ready),
      .op_a          (op_a),
      .op_b          (op_b),
      .array_select  (array_select),
      .clear_acc     (clear_acc),
      .load_weights  (load_weights),
      .compute_enable(compute_enable),
      .broadcast_mode(broadcast_mode),
      .a_inputs      (a_inputs),
      .b_inputs      (b_inputs),
      .all_ready     (all_ready),
      .busy          (busy),
      .done          (done)
   );

   always #5 clk = ~clk;

   // Control outputs packed; the IDLE/reset pattern is 11'h400 (cmd_ready only).
   assign ctl = {cmd_ready, op_ready, clear_acc, load_weights, compute_enable,
                 broadcast_mode, busy, done, array_select};

   typedef struct {
      int clr, ld, k, arr, bc, stall, rdy_low, rdy_val;
      int done_at, loads, comps, drains;
   } vec_t;

   typedef struct {
      logic         ld;
      logic [W-1:0] a;
      logic [W-1:0] b;
   } exp_t;

   vec_t          vecs[9];
   exp_t          exp_q[$];
   logic [W-1:0]  offer_a[$];
   logic [W-1:0]  offer_b[$];
   int            errors = 0;
   int            checks = 0;

   function automatic logic [W-1:0] rnd_bus();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic chk(input string nm, input longint act, input longint req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", nm, act, req);
      end
   endtask

   // Runs one command from acceptance to done; entered and left at posedge+1.
   task automatic run_vec(input int idx, input vec_t v);
      int cyc, loads, comps, drains, clears, bad, data_bad, done_cyc, nl;
      logic hs;
      exp_t e;
      exp_q.delete();
      offer_a.delete();
      offer_b.delete();
      nl = v.ld != 0 ? ARRAY_SIZE : 0;
      for (int i = 0; i < nl + v.k; i++) begin
         e.ld = (i < nl);
         e.a  = rnd_bus();
         e.b  = rnd_bus();
         offer_a.push_back(e.a);
         offer_b.push_back(e.b);
         if (e.ld) e.a = '0;
         exp_q.push_back(e);
      end
      cyc = 0; loads = 0; comps = 0; drains = 0; clears = 0;
      bad = 0; data_bad = 0; done_cyc = -1;
      while (cyc < 400 && done_cyc < 0) begin
         cmd_valid = 1'b1;
         if (cyc == 0) begin
            cmd_array     = 3'(v.arr);
            cmd_k_len     = K_BITS'(v.k);
            cmd_clear     = v.clr[0];
            cmd_load      = v.ld[0];
            cmd_broadcast = v.bc[0];
         end else begin
            // Conflicting command held while busy must be ignored.
            cmd_array     = ~3'(v.arr);
            cmd_k_len     = K_BITS'(v.k) ^ 8'h5A;
            cmd_clear     = ~v.clr[0];
            cmd_load      = ~v.ld[0];
            cmd_broadcast = ~v.bc[0];
         end
         op_valid  = (v.stall != 0) ? (cyc % 2 == 1) : 1'b1;
         op_a      = (offer_a.size() > 0) ? offer_a[0] : rnd_bus();
         op_b      = (offer_b.size() > 0) ? offer_b[0] : rnd_bus();
         all_ready = (cyc < v.rdy_low) ? 8'(v.rdy_val) : 8'hFF;
         @(negedge clk);
         if (cyc == 0 && cmd_ready !== 1'b1) bad++;
         if (cyc > 0 && (cmd_ready !== 1'b0 || busy !== 1'b1 ||
                         array_select !== 3'(v.arr) || broadcast_mode !== v.bc[0]))
            bad++;
         hs = op_valid && op_ready;
         if (clear_acc) begin
            clears++;
            if (cyc != 1) bad++;
         end
         if (load_weights || (compute_enable && hs)) begin
            if (!hs) bad++;
            if (exp_q.size() == 0) data_bad++;
            else begin
               e = exp_q.pop_front();
               if (e.ld !== load_weights || a_inputs !== e.a || b_inputs !== e.b)
                  data_bad++;
            end
            if (load_weights) loads++;
            else comps++;
         end else if (compute_enable) begin
            drains++;
            if (a_inputs !== '0 || b_inputs !== '0) bad++;
         end else if (a_inputs !== '0 || b_inputs !== '0) begin
            bad++;
         end
         if (hs && offer_a.size() > 0) begin
            void'(offer_a.pop_front());
            void'(offer_b.pop_front());
         end
         if (done) done_cyc = cyc;
         @(posedge clk);
         #1;
         cyc++;
      end
      cmd_valid = 1'b0;
      op_valid  = 1'b0;
      all_ready = 8'hFF;
      @(negedge clk);
      chk($sformatf("v%0d done_cycle", idx), done_cyc, v.done_at);
      chk($sformatf("v%0d load_beats", idx), loads, v.loads);
      chk($sformatf("v%0d compute_beats", idx), comps, v.comps);
      chk($sformatf("v%0d drain_cycles", idx), drains, v.drains);
      chk($sformatf("v%0d clear_pulses", idx), clears, v.clr);
      chk($sformatf("v%0d protocol_violations", idx), bad, 0);
      chk($sformatf("v%0d operand_data_errors", idx), data_bad, 0);
      chk($sformatf("v%0d beats_left", idx), exp_q.size(), 0);
      chk($sformatf("v%0d idle_after_done", idx), ctl, 11'h400);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n_done;
      //          clr ld  k   arr bc st rdy_low rdy_val done loads comps drains
      vecs[0] = '{1,  1,  4,  3,  0, 0, 0,  255, 30,  8, 4,   15};
      vecs[1] = '{1,  1,  4,  3,  0, 1, 0,  255, 42,  8, 4,   15};
      vecs[2] = '{0,  0,  1,  2,  1, 0, 22, 254, 23,  0, 1,   15};
      vecs[3] = '{0,  0,  1,  5,  0, 0, 22, 254, 18,  0, 1,   15};
      vecs[4] = '{0,  0,  1,  0,  0, 0, 22, 254, 23,  0, 1,   15};
      vecs[5] = '{0,  0,  0,  7,  0, 0, 0,  255, 2,   0, 0,   0};
      vecs[6] = '{0,  1,  0,  1,  0, 0, 0,  255, 10,  8, 0,   0};
      vecs[7] = '{1,  0,  0,  6,  0, 0, 0,  255, 3,   0, 0,   0};
      vecs[8] = '{0,  0,  255, 4, 0, 0, 0,  255, 272, 0, 255, 15};

      reset = 1'b0; cmd_valid = 1'b0; cmd_array = '0; cmd_k_len = '0;
      cmd_clear = 1'b0; cmd_load = 1'b0; cmd_broadcast = 1'b0; abort = 1'b0;
      op_valid = 1'b1; op_a = rnd_bus(); op_b = rnd_bus(); all_ready = 8'hFF;
      #12;
      chk("reset_outputs", ctl, 11'h400);
      chk("reset_buses", (a_inputs | b_inputs) != '0, 0);
      reset = 1'b1;
      op_valid = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

      // Abort on the third compute beat: no done, back in IDLE next cycle.
      cmd_valid = 1'b1; cmd_clear = 1'b0; cmd_load = 1'b0; cmd_k_len = 8'd4;
      cmd_array = 3'd1; cmd_broadcast = 1'b0; op_valid = 1'b1;
      @(negedge clk);
      chk("abort_accept_ready", cmd_ready, 1);
      @(posedge clk); #1; cmd_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1; abort = 1'b1;
      @(negedge clk);
      chk("abort_cycle_still_computes", compute_enable, 1);
      @(posedge clk); #1; abort = 1'b0;
      @(negedge clk);
      chk("abort_idle_outputs", ctl, 11'h400);
      n_done = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) n_done++;
      end
      chk("abort_no_done", n_done, 0);
      @(posedge clk); #1;

      // Abort while IDLE is ignored; the accepted command still completes.
      cmd_valid = 1'b1; cmd_k_len = 8'd0; cmd_array = 3'd2; abort = 1'b1;
      op_valid = 1'b0;
      @(negedge clk);
      @(posedge clk); #1; cmd_valid = 1'b0; abort = 1'b0;
      @(negedge clk);
      chk("idle_abort_ignored_busy", busy, 1);
      @(negedge clk);
      chk("idle_abort_ignored_done", done, 1);
      @(posedge clk); #1;

      // Asynchronous reset during DRAIN forces IDLE outputs immediately.
      cmd_valid = 1'b1; cmd_k_len = 8'd1; cmd_array = 3'd6; cmd_broadcast = 1'b1;
      op_valid = 1'b1;
      @(posedge clk); #1; cmd_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("drain_before_reset", {compute_enable, op_ready, broadcast_mode}, 3'b101);
      @(posedge clk); #2; reset = 1'b0; #1;
      chk("async_reset_outputs", ctl, 11'h400);
      chk("async_reset_buses", (a_inputs | b_inputs) != '0, 0);
      @(negedge clk);
      reset = 1'b1;
      op_valid = 1'b0;
      @(posedge clk); #1;
      run_vec(9, vecs[5]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
